// File: rtl/gcd_pkg.sv
// Shared types for the GCD host driver: FSM states, default data width and the operand-pair record.
package gcd_pkg;

  localparam int GCD_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_RESP
  } gcd_state_e;

  typedef struct packed {
    logic [GCD_DATA_W-1:0] a;
    logic [GCD_DATA_W-1:0] b;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_host_driver_fifo.sv
// Synchronous FIFO of packed operand pairs; pushes while full and pops while empty are ignored.
module gcd_cmd_fifo import gcd_pkg::*; #(
  parameter int WIDTH = 2 * GCD_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/gcd_host_driver.sv
// Host-side initiator for the GCD engine: queues operand pairs, sequences engine reset/run, returns results.
// Optional RUN watchdog: define GCD_DRV_TIMEOUT_EN to enable the TIMEOUT counter and res_err reporting.
module gcd_host_driver import gcd_pkg::*; #(
  parameter int DATA_W     = GCD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] gcd_a,
  output logic [DATA_W-1:0] gcd_b,
  output logic              gcd_rst,
  input  logic [DATA_W-1:0] gcd_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_gcd,
  output logic              res_err,
  output logic              busy
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  gcd_state_e        state_q, state_d;
  logic [DATA_W-1:0] gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic [DATA_W-1:0] res_gcd_q, res_gcd_d;
  logic              gcd_rst_q, gcd_rst_d;
  logic              res_valid_q, res_valid_d;
  logic              res_err_q, res_err_d;
  logic              busy_q, busy_d;
  logic              live_q;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;

  logic                  push, pop, full, empty;
  logic [CW-1:0]         fifo_count, count_next;
  logic [2*DATA_W-1:0]   pop_pair;
  logic [DATA_W-1:0]     pop_a, pop_b;
  logic                  timed_out;

  // live_q keeps in_ready low while reset is applied and for the reset cycle itself.
  assign in_ready = live_q && !full;
  assign push     = in_valid && in_ready;
  assign pop_a    = pop_pair[2*DATA_W-1:DATA_W];
  assign pop_b    = pop_pair[DATA_W-1:0];

  gcd_cmd_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (pop_pair),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] run_cnt_q, run_cnt_d;

  assign timed_out = (run_cnt_q == TCW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) run_cnt_q <= '0;
    else      run_cnt_q <= run_cnt_d;
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    res_gcd_d   = res_gcd_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    rst_cnt_d   = rst_cnt_q;
    pop         = 1'b0;
`ifdef GCD_DRV_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          gcd_a_d = pop_a;
          gcd_b_d = pop_b;
          // A zero operand needs no engine run: gcd(0,x) = x.
          if (pop_a == '0 || pop_b == '0) begin
            res_gcd_d   = pop_a | pop_b;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            rst_cnt_d = '0;
            state_d   = ST_RESET;
          end
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
`ifdef GCD_DRV_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef GCD_DRV_TIMEOUT_EN
        run_cnt_d = run_cnt_q + 1'b1;
`endif
        // A result arriving on the timeout cycle still counts as success.
        if (gcd_cout != '0) begin
          res_gcd_d   = gcd_cout;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timed_out) begin
          res_gcd_d   = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
    count_next = fifo_count + CW'(push) - CW'(pop);
    gcd_rst_d  = (state_d != ST_RUN);
    busy_d     = (state_d != ST_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      res_gcd_q   <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      gcd_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      rst_cnt_q   <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      res_gcd_q   <= res_gcd_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      gcd_rst_q   <= gcd_rst_d;
      busy_q      <= busy_d;
      rst_cnt_q   <= rst_cnt_d;
      live_q      <= 1'b1;
    end
  end

  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign gcd_rst   = gcd_rst_q;
  assign res_valid = res_valid_q;
  assign res_gcd   = res_gcd_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gcd_host_driver.sv
// Self-checking bench for gcd_host_driver with a behavioural GCD engine and a queue-based reference model.
module tb_gcd_host_driver;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [7:0] gcd_a, gcd_b, gcd_cout, res_gcd;
  logic       gcd_rst, res_valid, res_err, busy;
  logic       res_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  // Engine model state
  logic [7:0] eng_cout = '0;
  int         eng_cnt = 0;
  int         eng_lat = 1;
  int         lat_min = 1;
  int         lat_max = 8;
  bit         eng_dead = 1'b0;

  logic [8:0] resp_q[$];
  logic [8:0] exp_q[$];

  gcd_host_driver #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .RST_CYCLES (2),
    .TIMEOUT    (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .gcd_a     (gcd_a),
    .gcd_b     (gcd_b),
    .gcd_rst   (gcd_rst),
    .gcd_cout  (gcd_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_gcd   (res_gcd),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign gcd_cout = eng_cout;

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Engine: cleared while gcd_rst is high, result appears eng_lat cycles after release.
  always @(posedge clk) begin
    if (gcd_rst === 1'b1) begin
      eng_cnt  <= 0;
      eng_cout <= '0;
      eng_lat  <= $urandom_range(lat_max, lat_min);
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (!eng_dead && (eng_cnt + 1 >= eng_lat)) eng_cout <= ref_gcd(gcd_a, gcd_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 500) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL push_wait: in_ready=%b required 1 within 500 cycles", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rand_ready, input int budget, output int got);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      res_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      if (res_valid === 1'b1 && res_ready) begin
        resp_q.push_back({res_err, res_gcd});
        got++;
      end
      tick();
    end
    res_ready = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({in_ready, gcd_rst, res_valid, res_err, busy} !== 5'b01000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: {in_ready,gcd_rst,res_valid,res_err,busy}=%b required 01000",
               {in_ready, gcd_rst, res_valid, res_err, busy});
    end
    n_cmp++;
    if ({gcd_a, gcd_b, res_gcd} !== 24'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: gcd_a=%0d gcd_b=%0d res_gcd=%0d required 0", gcd_a, gcd_b, res_gcd);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int  rst_hi, run_cyc;
    bit  stable;
    lat_min = 3;
    lat_max = 3;
    push_pair(8'd48, 8'd18);
    tick();
    rst_hi = 0;
    stable = 1'b1;
    while (gcd_rst === 1'b1 && rst_hi < 20) begin
      if (gcd_a !== 8'd48 || gcd_b !== 8'd18) stable = 1'b0;
      rst_hi++;
      tick();
    end
    n_cmp++;
    if (rst_hi != 2) begin
      n_fail++;
      $display("[TB] FAIL basic_rst_width: gcd_rst high %0d cycles required 2", rst_hi);
    end
    run_cyc = 0;
    while (res_valid !== 1'b1 && run_cyc < 40) begin
      if (gcd_a !== 8'd48 || gcd_b !== 8'd18) stable = 1'b0;
      run_cyc++;
      tick();
    end
    n_cmp++;
    if (run_cyc != 4) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: res_valid %0d cycles after RUN entry required 4", run_cyc);
    end
    n_cmp++;
    if ({res_err, res_gcd} !== {1'b0, 8'd6}) begin
      n_fail++;
      $display("[TB] FAIL basic_result: err=%b gcd=%0d required err=0 gcd=6", res_err, res_gcd);
    end
    if (gcd_a !== 8'd48 || gcd_b !== 8'd18) stable = 1'b0;
    n_cmp++;
    if (!stable) begin
      n_fail++;
      $display("[TB] FAIL basic_operand_hold: stable=%b required 1", stable);
    end
    accept();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_release: res_valid=%b required 0", res_valid);
    end
    lat_min = 1;
    lat_max = 8;
  endtask

  task automatic test_zero_operands();
    logic [7:0] za[2];
    za[0] = 8'd35;
    za[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      push_pair(8'd0, za[i]);
      n_cmp++;
      if (res_valid !== 1'b0 || gcd_rst !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL zero_early_%0d: res_valid=%b gcd_rst=%b required 0/1", i, res_valid, gcd_rst);
      end
      tick();
      n_cmp++;
      if ({res_valid, res_err, res_gcd, gcd_rst} !== {1'b1, 1'b0, za[i], 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL zero_resp_%0d: valid=%b err=%b gcd=%0d gcd_rst=%b required 1/0/%0d/1",
                 i, res_valid, res_err, res_gcd, gcd_rst, za[i]);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa[5], pb[5];
    int got;
    pa = '{8'd12, 8'd9, 8'd7, 8'd20, 8'd14};
    pb = '{8'd8,  8'd6, 8'd5, 8'd15, 8'd21};
    resp_q.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(pa[i], pb[i]);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_full_%0d: in_ready=%b required 0", i, in_ready);
      end
      tick();
    end
    collect(5, 1'b0, 400, got);
    n_cmp++;
    if (got != 5) begin
      n_fail++;
      $display("[TB] FAIL bp_count: got %0d responses required 5", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (resp_q[i] !== {1'b0, ref_gcd(pa[i], pb[i])}) begin
        n_fail++;
        $display("[TB] FAIL bp_resp_%0d: got %0h required %0h", i, resp_q[i], {1'b0, ref_gcd(pa[i], pb[i])});
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    gcd_pair_t pairs[24];
    int got;
    resp_q.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      pairs[i].a = ($urandom_range(4, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      pairs[i].b = ($urandom_range(4, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      exp_q.push_back({1'b0, ref_gcd(pairs[i].a, pairs[i].b)});
    end
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          push_pair(pairs[i].a, pairs[i].b);
          repeat ($urandom_range(2, 0)) tick();
        end
      end
      collect(24, 1'b1, 4000, got);
    join
    n_cmp++;
    if (got != 24) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d responses required 24", got);
    end
    for (int i = 0; i < got; i++) begin
      n_cmp++;
      if (resp_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("[TB] FAIL b2b_resp_%0d: got %0h required %0h (a=%0d b=%0d)",
                 i, resp_q[i], exp_q[i], pairs[i].a, pairs[i].b);
      end
    end
  endtask

  task automatic test_timeout_and_reset();
    int run_cyc, waited, got;
    eng_dead = 1'b1;
    push_pair(8'd5, 8'd3);
    tick();
    waited = 0;
    while (gcd_rst === 1'b1 && waited < 20) begin
      waited++;
      tick();
    end
    run_cyc = 0;
    while (res_valid !== 1'b1 && run_cyc < 30) begin
      run_cyc++;
      tick();
    end
`ifdef GCD_DRV_TIMEOUT_EN
    n_cmp++;
    if (run_cyc != 11) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: res_valid %0d cycles after RUN entry required 11", run_cyc);
    end
    n_cmp++;
    if ({res_err, res_gcd} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL timeout_result: err=%b gcd=%0d required err=1 gcd=0", res_err, res_gcd);
    end
    accept();
    push_pair(8'd6, 8'd4);
    tick();
    waited = 0;
    while (gcd_rst === 1'b1 && waited < 20) begin
      waited++;
      tick();
    end
`else
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL no_timeout: res_valid=%b after %0d RUN cycles required 0", res_valid, run_cyc);
    end
`endif
    push_pair(8'd1, 8'd1);
    push_pair(8'd2, 8'd2);
    tick();
    n_cmp++;
    if ({busy, gcd_rst} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL midrun_state: busy=%b gcd_rst=%b required 1/0", busy, gcd_rst);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({in_ready, gcd_rst, res_valid, res_err, busy} !== 5'b01000 || {gcd_a, gcd_b, res_gcd} !== 24'h0) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset: flags=%b a=%0d b=%0d gcd=%0d required 01000/0/0/0",
               {in_ready, gcd_rst, res_valid, res_err, busy}, gcd_a, gcd_b, res_gcd);
    end
    rst = 1'b1;
    eng_dead = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if ({in_ready, busy, res_valid, gcd_rst} !== 4'b1001) begin
      n_fail++;
      $display("[TB] FAIL flushed: in_ready=%b busy=%b res_valid=%b gcd_rst=%b required 1/0/0/1",
               in_ready, busy, res_valid, gcd_rst);
    end
    resp_q.delete();
    push_pair(8'd10, 8'd4);
    collect(1, 1'b0, 100, got);
    n_cmp++;
    if (got != 1 || resp_q[0] !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("[TB] FAIL post_reset_job: got %0d responses first=%0h required 1 response 002",
               got, (got > 0) ? resp_q[0] : 9'h1ff);
    end
  endtask

  initial begin
    $display("[TB] starting gcd_host_driver bench");
    test_reset();
    test_basic();
    test_zero_operands();
    test_backpressure();
    test_back_to_back();
    test_timeout_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_host_driver.md
# gcd_host_driver

Host-side initiator for the GCD engine. Accepts operand pairs over a valid/ready command port and buffers them in a small FIFO. For each pair it resets the engine, holds the operands stable, and waits for a non-zero engine result. It returns the result, or an error on timeout, over a valid/ready response port. It sits between the system bus glue and the `gcd_ip_top` instance.

## Interface
- `DATA_W`, 8, operand/result width; must match the engine.
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `RST_CYCLES`, 2, cycles `gcd_rst` is held high per job; ≥1.
- `TIMEOUT`, 255, maximum RUN cycles before an error; ≥1.
- `clk  in  1  single clock, rising edge`
- `rst  in  1  synchronous, active-low reset`
- `in_valid  in  1  command pair valid`
- `in_ready  out  1  command FIFO not full`
- `in_a  in  DATA_W  operand A`
- `in_b  in  DATA_W  operand B`
- `gcd_a  out  DATA_W  to engine a, stable for the whole job`
- `gcd_b  out  DATA_W  to engine b, stable for the whole job`
- `gcd_rst  out  1  to engine rst, active-high`
- `gcd_cout  in  DATA_W  engine result; 0 = not done`
- `res_valid  out  1  response valid`
- `res_ready  in  1  response accepted`
- `res_gcd  out  DATA_W  GCD result (0 on error)`
- `res_err  out  1  timeout flag, valid with res_valid`
- `busy  out  1  FSM not in IDLE, or FIFO not empty`

## Operation
- **Command accept:** a push occurs when `in_valid & in_ready`. `in_ready = !full`. Push-when-full is refused even if a pop occurs in the same cycle. FIFO order is strict.
- **FSM states:** IDLE, RESET, RUN, RESP.
- **IDLE:** if the FIFO is non-empty, pop one entry and latch it into `gcd_a`/`gcd_b`.
  - If either operand is 0, load `res_gcd = a | b` (gcd(0,x)=x, gcd(0,0)=0) and `res_err=0`, then go to RESP. `gcd_rst` is not pulsed.
  - Otherwise go to RESET.
- **RESET:** `gcd_rst=1` for exactly `RST_CYCLES` cycles, then go to RUN. `gcd_cout` is ignored.
- **RUN:** `gcd_rst=0`; the cycle counter increments each cycle.
  - On the first cycle with `gcd_cout != 0`, capture it into `res_gcd` with `res_err=0` and go to RESP.
  - If the counter reaches `TIMEOUT` first, set `res_gcd=0` and `res_err=1`, then go to RESP.
  - If the capture and timeout conditions coincide, the result wins.
- **RESP:** `res_valid=1`, with `res_gcd`/`res_err` held stable until `res_ready`. On acceptance go to IDLE. A new pop can occur on the cycle after acceptance.
- **gcd_rst outside a job:** held at 1 in IDLE and RESP, so the engine stays quiescent between jobs.
- **Reset (`rst=0`):** the FIFO is flushed and the FSM goes to IDLE, including a reset mid-job.
  - Reset values: `in_ready=0`, `gcd_a=0`, `gcd_b=0`, `gcd_rst=1`, `res_valid=0`, `res_gcd=0`, `res_err=0`, `busy=0`.
  - `in_ready` rises on the first cycle after `rst` deasserts.
- **Arithmetic:** unsigned throughout. The counter is wide enough for `TIMEOUT`. No operand modification.

## Timing
- **Push to pop:** push at cycle N makes the entry poppable at N+1. The IDLE pop at N+1 drives `gcd_a`/`gcd_b` from N+2.
- **RESET window:** `gcd_rst` is high for cycles N+2 … N+1+`RST_CYCLES`. RUN starts at N+2+`RST_CYCLES`.
- **Result path:** `gcd_cout` non-zero at RUN cycle k gives `res_valid=1` at k+1. `gcd_cout` is sampled registered; there is no combinational path to `res_*`.
- **Zero shortcut:** `res_valid` at N+2.
- **Outputs:** all outputs are registered, except `in_ready`, which is derived from the registered FIFO count.

## Configuration
- **`GCD_DRV_TIMEOUT_EN` defined:** the RUN watchdog counter is present, and `res_err` behaves as specified.
- **`GCD_DRV_TIMEOUT_EN` undefined:** there is no counter. RUN waits indefinitely for non-zero `gcd_cout`, `res_err` is tied to 0, and `TIMEOUT` is ignored.

## Structure
- **Shared package `gcd_pkg`:** FSM state enum (IDLE/RESET/RUN/RESP), default `DATA_W`, and the operand-pair struct `{a,b}`.
- **Sub-module `gcd_cmd_fifo`:** synchronous FIFO of operand pairs, with push/pop/full/empty and a count. The FSM, counters and response register live in `gcd_host_driver`.

## Test plan
- **Basic job:** push (48,18) with the real engine. Expect `gcd_rst` high for 2 cycles, then `res_gcd=6`, `res_err=0`; `gcd_a`/`gcd_b` stable throughout the job.
- **Zero operands:** push (0,35) then (0,0). Expect responses 35 then 0 with no `gcd_rst` pulse after the idle hold, and `res_valid` 2 cycles after each push when idle.
- **Backpressure:** hold `res_ready=0` and push 5 pairs (12,8),(9,6),(7,5),(20,15),(14,21).
  - Expect `in_ready=0` once the FIFO is full.
  - After releasing `res_ready`, expect results 4,3,1,5,7 in order, with no loss or duplication.
- **Timeout:** stub engine drives `gcd_cout=0` forever, `TIMEOUT=10`. Expect `res_err=1`, `res_gcd=0` and `res_valid` 11 cycles after RUN entry. With the macro undefined, expect no response.
- **Reset mid-RUN:** assert `rst` mid-RUN with 2 entries queued. Expect all outputs at reset values, the FIFO empty, and the next push (10,4) to return 2.
